tlk2711_rd_arbiter: RTL

Shares the single HP0 AXI read master between two read requesters: port 0 is the TX DMA frame reader, and port 1 is the RX check/descriptor reader. It arbitrates AR requests and issues one burst at a time on the master AR channel. A grant FIFO records which port owns each outstanding burst, so R beats are steered back to that port in order. The block sits between the DMA read engines and the `m_axi_*` read ports of `tlk2711_top`.

---
 rtl/tlk2711_rd_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/tlk2711_rd_arbiter.sv
// tlk2711_rd_arbiter: shares one AXI read master between the TX DMA frame
// reader (port 0) and the RX check/descriptor reader (port 1).
//
// Ports:
//   clk, rst_n          single clock, synchronous active-low reset
//   s0_ar*, s1_ar*      requester AR channels (valid/ready/addr/len)
//   s0_r*, s1_r*        requester R channels, steered by the grant FIFO
//   m_axi_ar*, m_axi_r* shared AXI read master
//   o_outstanding       grant FIFO occupancy
//   o_resp_err          sticky, set by any accepted beat with rresp != 0
//
// Build option: define RD_ARB_FIXED_PRIO_EN for fixed priority
// (port 0 always wins); default is round-robin.
module tlk2711_rd_arbiter #(
  parameter int ADDR_WIDTH      = 40,
  parameter int DATA_WIDTH      = 128,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s0_arvalid,
  output logic                  s0_arready,
  input  logic [ADDR_WIDTH-1:0] s0_araddr,
  input  logic [7:0]            s0_arlen,
  output logic                  s0_rvalid,
  input  logic                  s0_rready,
  output logic [DATA_WIDTH-1:0] s0_rdata,
  output logic                  s0_rlast,
  input  logic                  s1_arvalid,
  output logic                  s1_arready,
  input  logic [ADDR_WIDTH-1:0] s1_araddr,
  input  logic [7:0]            s1_arlen,
  output logic                  s1_rvalid,
  input  logic                  s1_rready,
  output logic [DATA_WIDTH-1:0] s1_rdata,
  output logic                  s1_rlast,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic [3:0]            m_axi_arid,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  output logic [4:0]            o_outstanding,
  output logic                  o_resp_err
);

  localparam int PW = $clog2(MAX_OUTSTANDING);

  typedef enum logic {
    IDLE,
    ISSUE
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [7:0]              len_q;
  logic [MAX_OUTSTANDING-1:0] owner_q;
  logic [PW-1:0]           wr_ptr_q;
  logic [PW-1:0]           rd_ptr_q;
  logic [4:0]              count_q;
  logic                    resp_err_q;

  logic full;
  logic empty;
  logic head;
  logic grant;
  logic win;
  logic pop;

`ifndef RD_ARB_FIXED_PRIO_EN
  logic last_grant_q;
`endif

  assign full  = count_q == 5'(MAX_OUTSTANDING);
  assign empty = count_q == 5'd0;
  assign head  = owner_q[rd_ptr_q];

  // win: 0 selects port 0, 1 selects port 1
  always_comb begin
    win = 1'b0;
`ifdef RD_ARB_FIXED_PRIO_EN
    win = !s0_arvalid;
`else
    unique case (1'b1)
      s0_arvalid && s1_arvalid:  win = !last_grant_q;
      s0_arvalid && !s1_arvalid: win = 1'b0;
      default:                   win = 1'b1;
    endcase
`endif
  end

  // The FIFO push happens on the same cycle as the grant.
  assign grant = rst_n && (state_q == IDLE) && !full &&
                 (s0_arvalid || s1_arvalid);

  assign s0_arready = grant && !win;
  assign s1_arready = grant && win;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant) state_d = ISSUE;
      ISSUE:   if (m_axi_arready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign m_axi_arvalid = state_q == ISSUE;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = len_q;
  assign m_axi_arsize  = 3'($clog2(DATA_WIDTH / 8));
  assign m_axi_arburst = 2'b01;
  assign m_axi_arid    = 4'd0;

  // R steering: stray beats with no owner are stalled, not dropped.
  assign m_axi_rready = !empty && (head ? s1_rready : s0_rready);
  assign s0_rvalid    = m_axi_rvalid && !empty && !head;
  assign s1_rvalid    = m_axi_rvalid && !empty && head;
  assign s0_rlast     = m_axi_rlast && !empty && !head;
  assign s1_rlast     = m_axi_rlast && !empty && head;
  assign s0_rdata     = m_axi_rdata;
  assign s1_rdata     = m_axi_rdata;

  assign pop = m_axi_rvalid && m_axi_rready && m_axi_rlast;

  assign o_outstanding = count_q;
  assign o_resp_err    = resp_err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      resp_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        addr_q            <= win ? s1_araddr : s0_araddr;
        len_q             <= win ? s1_arlen : s0_arlen;
        owner_q[wr_ptr_q] <= win;
        wr_ptr_q          <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      unique case ({grant, pop})
        2'b10:   count_q <= count_q + 5'd1;
        2'b01:   count_q <= count_q - 5'd1;
        default: count_q <= count_q;
      endcase
      if (m_axi_rvalid && m_axi_rready && (m_axi_rresp != 2'b00))
        resp_err_q <= 1'b1;
    end
  end

`ifndef RD_ARB_FIXED_PRIO_EN
  // Reset to 1 so port 0 wins the first contended grant.
  always_ff @(posedge clk) begin
    if (!rst_n) last_grant_q <= 1'b1;
    else if (grant) last_grant_q <= win;
  end
`endif

endmodule
